mips_data_mem: RTL and testbench
================================

// Module: mips_data_mem
// PURPOSE
//  Parametrised data memory for the MIPS core, successor to the single-cycle word memory.
//  Adds byte/half/word access (LB/LBU/LH/LHU/SB/SH/SW/LW) and a valid/ready request/response handshake.
//  Adds a configurable read/write latency, and alignment plus range error reporting.
//  Sits between the ALU address output and the MemtoReg writeback mux; the controlling core stalls on req_ready/rsp_valid.
// PARAMETERS
//  DEPTH    128  number of 32-bit words; any value >= 1
//  ADDR_W   32   request byte-address width; must be >= 2 + clog2(DEPTH)
//  LATENCY  1    clock edges from request accept to rsp_valid; legal range 1..15
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       block can accept a request (high only in IDLE)
//  req_write  in   1       1 = store, 0 = load
//  req_size   in   2       0 byte, 1 half, 2 word, 3 reserved (flagged as error)
//  req_signed in   1       loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       consumer takes the response
//  rsp_rdata  out  32      load data, extended; 0 for stores and for errors
//  rsp_err    out  1       misaligned access, reserved size, or word index >= DEPTH
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
//    Memory array contents are not reset.
//  - FSM states:
//    IDLE -(req_valid & req_ready)-> WAIT
//    WAIT -(cnt==LATENCY-1)-> RESP
//    RESP -(rsp_ready)-> IDLE
//  - Accept happens on the edge with req_valid=1 in IDLE.
//    All request fields are sampled there; later input changes are ignored.
//  - Stores commit to the array on the accept edge. Only the addressed byte lanes are written.
//  - Load data is captured from the array on the edge entering RESP.
//  - rsp_valid rises exactly LATENCY edges after accept.
//    rsp_valid and rsp_rdata/rsp_err stay stable until the rsp_ready edge.
//  - No back-to-back accept: req_ready=0 in WAIT and RESP. After the rsp_ready edge, IDLE is re-entered with req_ready=1.
//  - Addressing:
//    word index = req_addr[ADDR_W-1:2]; lane = req_addr[1:0].
//    Byte: any lane. Half: lane 0 or 2. Word: lane 0.
//  - Write byte enables:
//    byte: 1<<lane
//    half: 4'b0011<<lane
//    word: 4'b1111
//  - Read extract: byte = mem[8*lane +: 8]; half = mem[8*lane +: 16]; word = the full word.
//    The extracted value is extended per req_signed.
//  - Error (misaligned, size==3, or index >= DEPTH):
//    store is suppressed (array unchanged); response still issued after LATENCY; rsp_err=1, rsp_rdata=0.
//  - Address bits above the index are never wrapped; an out-of-range index is always an error.
//  - rsp_ready may be held high continuously; the response then occupies exactly one cycle in RESP.
//  - Reset mid-operation:
//    a committed store stays committed; a pending load is discarded; no response is produced.
// CONFIGURATION
//  MIPS_DMEM_INIT_EN defined: at time 0 every word is 0, except words 0/1/2 = 5/6/7.
//  MIPS_DMEM_INIT_EN undefined: no initial block; contents are X until written.
//  Handshake and timing are identical in both builds.
// STRUCTURE
//  Shared package mips_pkg:
//    size encodings SZ_BYTE/SZ_HALF/SZ_WORD
//    dmem state enum IDLE/WAIT/RESP
//    function lane_mask(size, lane) -> [3:0]
//  One sub-module, mips_dmem_align (combinational): takes size/lane/signed/raw word and returns
//  byte-enable mask, shifted write data, extended read data and the misalign flag.
//  The FSM, counter and array live in mips_data_mem.
// TESTING (bench built with MIPS_DMEM_INIT_EN, LATENCY=3, DEPTH=128)
//  1. Reset, then LW addr 0x4 -> rsp_valid exactly 3 edges after accept; rdata=6; err=0.
//  2. SW 0xAABBCCDD @0x10; then LB signed @0x11 -> 0xFFFFFFCC; LBU @0x13 -> 0x000000AA;
//     LH signed @0x12 -> 0xFFFFAABB.
//  3. SB 0x5A @0x12 over that word; then LW @0x10 -> 0xAA5ACCDD (other lanes untouched).
//  4. LH @0x11 and SW @0x102 -> rsp_err=1, rdata=0; word at 0x100 unchanged.
//     Then LW @0x200 (index 128) -> rsp_err=1.
//  5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable; req_valid=1 during that time is not accepted.
//  6. Assert reset_n=0 one cycle after accepting LW @0x8 -> rsp_valid=0, req_ready=1 after release;
//     no stray response.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS data-memory slice:
//   - access size encodings SZ_BYTE / SZ_HALF / SZ_WORD (SZ_RSVD is illegal)
//   - dmem_state_t : request FSM states IDLE / WAIT / RESP
//   - lane_mask()  : byte-enable mask for a given size and byte lane
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // A misaligned half at lane 3 truncates to a single lane here; such an
   // access is always flagged as an error and never written.
   function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] lane);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << lane;
         SZ_HALF: m = 4'b0011 << lane;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mips_dmem_align.sv
// ---------------------------------------------------------------------------
// mips_dmem_align
// Combinational lane steering for byte/half/word accesses.
// Ports:
//   size      in  2   access size (mips_pkg SZ_*)
//   lane      in  2   byte address bits [1:0]
//   sign_ext  in  1   1 = sign-extend loads, 0 = zero-extend
//   wdata     in  32  right-aligned store data
//   raw       in  32  full word read from the array
//   be        out 4   byte-enable mask for stores
//   wdata_sh  out 32  store data moved onto its byte lanes
//   rdata_ext out 32  extracted and extended load data
//   misalign  out 1   half not on lane 0/2, or word not on lane 0
// ---------------------------------------------------------------------------
module mips_dmem_align
   import mips_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] raw,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [31:0] raw_sh;

   assign be       = lane_mask(size, lane);
   assign wdata_sh = wdata << {lane, 3'b000};
   assign raw_sh   = raw >> {lane, 3'b000};

   always_comb begin
      rdata_ext = 32'd0;
      misalign  = 1'b0;
      case (size)
         SZ_BYTE: begin
            rdata_ext = {{24{sign_ext & raw_sh[7]}}, raw_sh[7:0]};
         end
         SZ_HALF: begin
            rdata_ext = {{16{sign_ext & raw_sh[15]}}, raw_sh[15:0]};
            misalign  = lane[0];
         end
         SZ_WORD: begin
            rdata_ext = raw;
            misalign  = (lane != 2'd0);
         end
         default: begin
            // Reserved size is reported separately by the caller.
            rdata_ext = 32'd0;
            misalign  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mips_data_mem.sv
// ---------------------------------------------------------------------------
// mips_data_mem
// Byte/half/word data memory with a valid/ready request/response handshake,
// a fixed LATENCY from accept to response, and error reporting for
// misaligned accesses, the reserved size and out-of-range word indices.
// Optional build macro MIPS_DMEM_INIT_EN: preload every word with 0 except
// words 0/1/2 = 5/6/7. Without it the array starts undefined.
// Parameters: DEPTH (words), ADDR_W (byte-address width), LATENCY (1..15).
// Ports:
//   clock      in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       request can be accepted (IDLE only)
//   req_write  in   1       1 = store, 0 = load
//   req_size   in   2       0 byte, 1 half, 2 word, 3 reserved
//   req_signed in   1       loads: sign-extend when 1
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   32      right-aligned store data
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       response taken
//   rsp_rdata  out  32      extended load data (0 for stores/errors)
//   rsp_err    out  1       access error
// ---------------------------------------------------------------------------
module mips_data_mem
   import mips_pkg::*;
#(
   parameter int DEPTH   = 128,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-3:0] DEPTH_V = (ADDR_W-2)'(DEPTH);
   localparam logic [3:0]      LAST_CNT = 4'(LATENCY - 1);

   logic [31:0] mem [DEPTH];

   dmem_state_t state, state_nx;
   logic [3:0]  cnt;

   // request fields held for the duration of the transaction
   logic          write_q;
   logic [1:0]    size_q;
   logic [1:0]    lane_q;
   logic          signed_q;
   logic          err_q;
   logic [IW-1:0] idx_q;

   logic          accept;
   logic          load_cap;
   logic          in_range;
   logic          req_err;
   logic [IW-1:0] widx;

   logic [1:0]  al_size;
   logic [1:0]  al_lane;
   logic        al_signed;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_misalign;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_ready & req_valid;
   assign load_cap  = (state == WAIT) && (cnt == LAST_CNT);

   // Upper address bits are never wrapped: the full index is range-checked.
   assign in_range = (req_addr[ADDR_W-1:2] < DEPTH_V);
   assign widx     = req_addr[IW+1:2];
   assign req_err  = al_misalign | (req_size == SZ_RSVD) | ~in_range;

   // One aligner serves both directions: it sees the live request while
   // IDLE (store lanes, misalign check) and the held fields afterwards
   // (load extraction).
   always_comb begin
      al_size   = size_q;
      al_lane   = lane_q;
      al_signed = signed_q;
      if (state == IDLE) begin
         al_size   = req_size;
         al_lane   = req_addr[1:0];
         al_signed = req_signed;
      end
   end

   mips_dmem_align u_align (
      .size      (al_size),
      .lane      (al_lane),
      .sign_ext  (al_signed),
      .wdata     (req_wdata),
      .raw       (mem[idx_q]),
      .be        (al_be),
      .wdata_sh  (al_wdata),
      .rdata_ext (al_rdata),
      .misalign  (al_misalign)
   );

   // ---- FSM next state ----
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = WAIT;
         WAIT:    if (cnt == LAST_CNT) state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---- control registers (state, latency counter, response) ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept)
            cnt <= 4'd0;
         else if (state == WAIT)
            cnt <= cnt + 4'd1;
         if (load_cap) begin
            rsp_err   <= err_q;
            rsp_rdata <= (err_q | write_q) ? 32'd0 : al_rdata;
         end
      end
   end

   // ---- request capture (data path, no reset) ----
   always_ff @(posedge clock) begin
      if (accept) begin
         write_q  <= req_write;
         size_q   <= req_size;
         lane_q   <= req_addr[1:0];
         signed_q <= req_signed;
         err_q    <= req_err;
         idx_q    <= widx;
      end
   end

   // ---- array write: stores commit on the accept edge ----
   always_ff @(posedge clock) begin
      if (accept && req_write && !req_err) begin
         for (int i = 0; i < 4; i++) begin
            if (al_be[i]) mem[widx][8*i +: 8] <= al_wdata[8*i +: 8];
         end
      end
   end

`ifdef MIPS_DMEM_INIT_EN
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = (i < 3) ? 32'(i + 5) : 32'd0;
      end
   end
`endif

endmodule

// File: tb/tb_mips_data_mem.sv
// ---------------------------------------------------------------------------
// tb_mips_data_mem
// Directed bench for mips_data_mem with DEPTH=128, LATENCY=3.
// ---------------------------------------------------------------------------
module tb_mips_data_mem;

   localparam int DEPTH   = 128;
   localparam int ADDR_W  = 32;
   localparam int LATENCY = 3;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   mips_data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request in IDLE, scramble the inputs right after the accept
   // edge, then wait (bounded) for rsp_valid. edges = accept-to-valid edges.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int edges);
      @(negedge clock);
      chk("req_ready_before", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clock);
      #1;
      req_valid  = 1'b0;
      req_write  = ~wr;
      req_size   = 2'd3;
      req_signed = ~sg;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h1357_9BDF;
      edges = 0;
      while (!rsp_valid && edges < 20) begin
         @(posedge clock);
         #1;
         edges++;
      end
      chk("rsp_arrived", {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic complete();
      @(negedge clock);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      chk("rsp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
      chk("req_ready_back", {31'd0, req_ready}, 32'd1);
   endtask

   // Full transaction returning the response fields.
   task automatic xact(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
      int e;
      issue(wr, sz, sg, addr, wd, e);
      rd = rsp_rdata;
      er = rsp_err;
      complete();
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          e;
      int          stray;

      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      rsp_ready  = 1'b0;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

`ifndef MIPS_DMEM_INIT_EN
      // without the preload, give word 1 the value the preload would have
      xact(1'b1, 2'd2, 1'b0, 32'h4, 32'd6, rd, er);
`endif

      // 1. LW 0x4: latency and preloaded data
      issue(1'b0, 2'd2, 1'b0, 32'h4, 32'd0, e);
      chk("lw4_latency", 32'(e), 32'd3);
      chk("lw4_rdata", rsp_rdata, 32'd6);
      chk("lw4_err", {31'd0, rsp_err}, 32'd0);
      complete();

      // 2. SW then byte/half loads
      xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hAABB_CCDD, rd, er);
      chk("sw10_rdata", rd, 32'd0);
      chk("sw10_err", {31'd0, er}, 32'd0);
      xact(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, rd, er);
      chk("lb11", rd, 32'hFFFF_FFCC);
      xact(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, rd, er);
      chk("lbu13", rd, 32'h0000_00AA);
      xact(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, rd, er);
      chk("lh12", rd, 32'hFFFF_AABB);
      chk("lh12_err", {31'd0, er}, 32'd0);

      // 3. SB into lane 2 only (upper wdata bits must be ignored)
      xact(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFF_FF5A, rd, er);
      xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er);
      chk("lw10_after_sb", rd, 32'hAA5A_CCDD);
      xact(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, rd, er);
      chk("lhu12", rd, 32'h0000_AA5A);

      // 4. error cases
      xact(1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, rd, er);
      xact(1'b0, 2'd1, 1'b1, 32'h11, 32'd0, rd, er);
      chk("lh11_err", {31'd0, er}, 32'd1);
      chk("lh11_rdata", rd, 32'd0);
      xact(1'b1, 2'd2, 1'b0, 32'h102, 32'hDEAD_BEEF, rd, er);
      chk("sw102_err", {31'd0, er}, 32'd1);
      chk("sw102_rdata", rd, 32'd0);
      xact(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, rd, er);
      chk("lw100_unchanged", rd, 32'h1234_5678);
      chk("lw100_err", {31'd0, er}, 32'd0);
      issue(1'b0, 2'd2, 1'b0, 32'h200, 32'd0, e);
      chk("lw200_latency", 32'(e), 32'd3);
      chk("lw200_err", {31'd0, rsp_err}, 32'd1);
      chk("lw200_rdata", rsp_rdata, 32'd0);
      complete();
      xact(1'b0, 2'd3, 1'b0, 32'h0, 32'd0, rd, er);
      chk("size3_err", {31'd0, er}, 32'd1);
      xact(1'b1, 2'd0, 1'b0, 32'h8000_0010, 32'h0000_0011, rd, er);
      chk("sb_high_addr_err", {31'd0, er}, 32'd1);

      // 5. response held under backpressure; new request refused
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, e);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h10;
      req_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_rdata", rsp_rdata, 32'hAA5A_CCDD);
         chk("hold_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      complete();
      xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er);
      chk("lw10_no_stray_store", rd, 32'hAA5A_CCDD);

      // 6. reset one cycle after accepting LW 0x8
      @(negedge clock);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size  = 2'd2;
      req_addr  = 32'h8;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         #1;
         if (rsp_valid) stray++;
      end
      chk("no_stray_rsp", 32'(stray), 32'd0);
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
      xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er);
      chk("lw10_after_rst", rd, 32'hAA5A_CCDD);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
